// File: rtl/mic_frame_packer_if.sv
// mic_frame_packer_if
//   Bundles the sample input side and the frame output side of the packer.
//   slave  : packer view (samples in, frames out)
//   master : producer/consumer view (samples out, frames in)
//   Signals:
//     mic / mic_valid / mode / flush  - multichannel sample beat and controls
//     result / result_count           - head frame and its number of valid slots
//     result_valid / result_ready     - output handshake
//     level / overflow                - frames buffered, sticky drop flag
interface mic_frame_packer_if #(
  parameter int SAMPLE_W = 24,
  parameter int CHANNELS = 1,
  parameter int OUT_W    = 256,
  parameter int DEPTH    = 4
);
  localparam int SLOTS = OUT_W / SAMPLE_W;

  logic [CHANNELS*SAMPLE_W-1:0] mic;
  logic                         mic_valid;
  logic                         mode;
  logic                         flush;
  logic [OUT_W-1:0]             result;
  logic [$clog2(SLOTS+1)-1:0]   result_count;
  logic                         result_valid;
  logic                         result_ready;
  logic [$clog2(DEPTH+1)-1:0]   level;
  logic                         overflow;

  modport slave (
    input  mic, mic_valid, mode, flush, result_ready,
    output result, result_count, result_valid, level, overflow
  );

  modport master (
    output mic, mic_valid, mode, flush, result_ready,
    input  result, result_count, result_valid, level, overflow
  );
endinterface

// File: rtl/mic_frame_packer.sv
// mic_frame_packer
//   Packs free-running multichannel mic samples (optionally averaged in pairs
//   per channel) into wide frames, buffers finished frames in a small FIFO and
//   releases them through a valid/ready handshake.
//   Ports:
//     clk  - single rising-edge clock
//     rst  - synchronous active-high reset
//     bus  - mic_frame_packer_if.slave (sample beats in, frames out)
module mic_frame_packer #(
  parameter int SAMPLE_W = 24,
  parameter int CHANNELS = 1,
  parameter int OUT_W    = 256,
  parameter int DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst,
  mic_frame_packer_if.slave bus
);
  localparam int SLOTS = OUT_W / SAMPLE_W;
  localparam int CAP   = (SLOTS / CHANNELS) * CHANNELS;
  localparam int FW    = $clog2(SLOTS + 1);
  localparam int LW    = $clog2(DEPTH + 1);
  localparam int PW    = $clog2(DEPTH);

  // Frame assembly state
  logic [FW-1:0]       fill_reg;
  logic                phase_reg;
  logic                mode_reg;
  logic [SAMPLE_W-1:0] hold_reg [CHANNELS];
  logic [OUT_W-1:0]    frame_reg;

  logic                eff_mode;
  logic                emit;
  logic                close;
  logic [SAMPLE_W-1:0] beat_sample [CHANNELS];
  logic [FW-1:0]       fill_next;
  logic [OUT_W-1:0]    frame_next;

  // Frame FIFO with registered head
  logic [OUT_W-1:0]    mem_frame [DEPTH];
  logic [FW-1:0]       mem_count [DEPTH];
  logic [PW-1:0]       wr_ptr_reg;
  logic [PW-1:0]       rd_ptr_reg;
  logic [PW-1:0]       rd_ptr_next;
  logic [LW-1:0]       level_reg;
  logic [LW-1:0]       level_next;
  logic [OUT_W-1:0]    result_reg;
  logic [FW-1:0]       result_count_reg;
  logic                result_valid_reg;
  logic                overflow_reg;
  logic                pop;
  logic                push;

  // Mode follows the input only at a frame start; otherwise the latched value rules.
  assign eff_mode = (fill_reg == '0 && !phase_reg) ? bus.mode : mode_reg;
  assign emit     = bus.mic_valid && (!eff_mode || phase_reg);

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [SAMPLE_W-1:0] raw;
      logic [SAMPLE_W:0]   sum;
      assign raw = bus.mic[gi*SAMPLE_W +: SAMPLE_W];
      // One bit of sign extension keeps the pair sum exact; bits [SAMPLE_W:1]
      // are that sum shifted right arithmetically by one.
      assign sum = {hold_reg[gi][SAMPLE_W-1], hold_reg[gi]} + {raw[SAMPLE_W-1], raw};
      assign beat_sample[gi] = eff_mode ? sum[SAMPLE_W:1] : raw;
    end
  endgenerate

  always_comb begin
    frame_next = frame_reg;
    fill_next  = fill_reg;
    if (emit) begin
      for (int k = 0; k < SLOTS; k++) begin
        for (int c = 0; c < CHANNELS; c++) begin
          if (int'(fill_reg) + c == k) begin
            frame_next[k*SAMPLE_W +: SAMPLE_W] = beat_sample[c];
          end
        end
      end
      fill_next = fill_reg + FW'(CHANNELS);
    end
  end

  // The beat of this cycle is folded in before deciding to close.
  assign close = (fill_next == FW'(CAP)) || (bus.flush && fill_next != '0);
  assign pop   = result_valid_reg && bus.result_ready;
  // A pop in the same cycle frees room for the closing frame.
  assign push  = close && ((level_reg != LW'(DEPTH)) || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_reg  <= '0;
      phase_reg <= 1'b0;
      mode_reg  <= 1'b0;
      frame_reg <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        hold_reg[c] <= '0;
      end
    end else begin
      mode_reg <= eff_mode;
      if (bus.mic_valid && eff_mode && !phase_reg) begin
        for (int c = 0; c < CHANNELS; c++) begin
          hold_reg[c] <= bus.mic[c*SAMPLE_W +: SAMPLE_W];
        end
      end
      if (close) begin
        frame_reg <= '0;
        fill_reg  <= '0;
      end else begin
        frame_reg <= frame_next;
        fill_reg  <= fill_next;
      end
      // Flush always drops a held first-of-pair sample.
      if (close || bus.flush) begin
        phase_reg <= 1'b0;
      end else if (bus.mic_valid && eff_mode) begin
        phase_reg <= ~phase_reg;
      end
    end
  end

  always_comb begin
    level_next = level_reg;
    if (push && !pop) begin
      level_next = level_reg + LW'(1);
    end else if (pop && !push) begin
      level_next = level_reg - LW'(1);
    end
    rd_ptr_next = rd_ptr_reg + PW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_frame[wr_ptr_reg] <= frame_next;
      mem_count[wr_ptr_reg] <= fill_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      level_reg        <= '0;
      result_reg       <= '0;
      result_count_reg <= '0;
      result_valid_reg <= 1'b0;
      overflow_reg     <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + PW'(push);
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= level_next;
      if (close && !push) begin
        overflow_reg <= 1'b1;
      end
      if (level_next == '0) begin
        result_reg       <= '0;
        result_count_reg <= '0;
        result_valid_reg <= 1'b0;
      end else if (level_reg == LW'(pop)) begin
        // Nothing left in storage after the pop: the new frame goes straight to the head.
        result_reg       <= frame_next;
        result_count_reg <= fill_next;
        result_valid_reg <= 1'b1;
      end else begin
        result_reg       <= mem_frame[rd_ptr_next];
        result_count_reg <= mem_count[rd_ptr_next];
        result_valid_reg <= 1'b1;
      end
    end
  end

  assign bus.result       = result_reg;
  assign bus.result_count = result_count_reg;
  assign bus.result_valid = result_valid_reg;
  assign bus.level        = level_reg;
  assign bus.overflow     = overflow_reg;
endmodule

// File: tb/tb_mic_frame_packer.sv
// tb_mic_frame_packer
//   Drives a 1-channel and a 3-channel packer. A reference model turns the
//   applied beats into expected frames (queued per instance); a monitor
//   compares every presented head frame, plus valid/level/overflow each cycle.
module tb_mic_frame_packer;
  localparam int SW    = 24;
  localparam int OW    = 256;
  localparam int DEPTH = 4;

  typedef struct {
    logic [255:0] data;
    int           count;
  } frame_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_drv   [2];
  logic [71:0] mic_drv   [2];
  logic        valid_drv [2];
  logic        mode_drv  [2];
  logic        flush_drv [2];
  logic        ready_drv [2];

  mic_frame_packer_if #(.SAMPLE_W(SW), .CHANNELS(1), .OUT_W(OW), .DEPTH(DEPTH)) bus_a ();
  mic_frame_packer_if #(.SAMPLE_W(SW), .CHANNELS(3), .OUT_W(OW), .DEPTH(DEPTH)) bus_b ();

  assign bus_a.mic          = mic_drv[0][23:0];
  assign bus_a.mic_valid    = valid_drv[0];
  assign bus_a.mode         = mode_drv[0];
  assign bus_a.flush        = flush_drv[0];
  assign bus_a.result_ready = ready_drv[0];
  assign bus_b.mic          = mic_drv[1];
  assign bus_b.mic_valid    = valid_drv[1];
  assign bus_b.mode         = mode_drv[1];
  assign bus_b.flush        = flush_drv[1];
  assign bus_b.result_ready = ready_drv[1];

  mic_frame_packer #(.SAMPLE_W(SW), .CHANNELS(1), .OUT_W(OW), .DEPTH(DEPTH)) dut_a (
    .clk(clk), .rst(rst_drv[0]), .bus(bus_a));
  mic_frame_packer #(.SAMPLE_W(SW), .CHANNELS(3), .OUT_W(OW), .DEPTH(DEPTH)) dut_b (
    .clk(clk), .rst(rst_drv[1]), .bus(bus_b));

  logic [255:0] res_mon [2];
  logic [3:0]   cnt_mon [2];
  logic         val_mon [2];
  logic [2:0]   lvl_mon [2];
  logic         ovf_mon [2];
  assign res_mon[0] = bus_a.result;
  assign res_mon[1] = bus_b.result;
  assign cnt_mon[0] = bus_a.result_count;
  assign cnt_mon[1] = bus_b.result_count;
  assign val_mon[0] = bus_a.result_valid;
  assign val_mon[1] = bus_b.result_valid;
  assign lvl_mon[0] = bus_a.level;
  assign lvl_mon[1] = bus_b.level;
  assign ovf_mon[0] = bus_a.overflow;
  assign ovf_mon[1] = bus_b.overflow;

  // Reference model state: samples collected for the open frame, pair buffer,
  // latched mode, frames the FIFO should hold, sticky drop flag.
  int     cur     [2][10];
  int     cur_n   [2];
  int     held    [2][3];
  int     phase_m [2];
  int     mode_m  [2];
  int     lvl_m   [2];
  logic   ovf_m   [2];
  logic   rst_seen[2];
  frame_t exp_q0[$];
  frame_t exp_q1[$];

  int   pass_cnt  = 0;
  int   total_cnt = 0;
  logic final_chk = 1'b0;

  function automatic int sext(input logic [23:0] x);
    return int'($signed(x));
  endfunction

  initial begin : model_proc
    int     ch, cap, s, t;
    frame_t f;
    forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
        ch  = (i == 0) ? 1 : 3;
        cap = (10 / ch) * ch;
        if (rst_drv[i]) begin
          cur_n[i] = 0; phase_m[i] = 0; mode_m[i] = 0; lvl_m[i] = 0;
          ovf_m[i] = 1'b0; rst_seen[i] = 1'b1;
          if (i == 0) exp_q0.delete(); else exp_q1.delete();
        end else begin
          rst_seen[i] = 1'b0;
          if (lvl_m[i] > 0 && ready_drv[i]) lvl_m[i]--;
          if (cur_n[i] == 0 && phase_m[i] == 0) mode_m[i] = int'(mode_drv[i]);
          if (valid_drv[i]) begin
            for (int c = 0; c < ch; c++) begin
              s = sext(mic_drv[i][c*24 +: 24]);
              if (mode_m[i] == 0)       cur[i][cur_n[i]+c] = s;
              else if (phase_m[i] == 0) held[i][c] = s;
              else                      cur[i][cur_n[i]+c] = (held[i][c] + s) >>> 1;
            end
            if (mode_m[i] == 0 || phase_m[i] == 1) cur_n[i] += ch;
            if (mode_m[i] == 1) phase_m[i] = 1 - phase_m[i];
          end
          if (cur_n[i] == cap || (flush_drv[i] && cur_n[i] > 0)) begin
            f.data = '0;
            for (int k = 0; k < cur_n[i]; k++) begin
              t = cur[i][k];
              f.data[k*24 +: 24] = t[23:0];
            end
            f.count = cur_n[i];
            if (lvl_m[i] < DEPTH) begin
              lvl_m[i]++;
              if (i == 0) exp_q0.push_back(f); else exp_q1.push_back(f);
            end else begin
              ovf_m[i] = 1'b1;
            end
            cur_n[i]   = 0;
            phase_m[i] = 0;
          end
          if (flush_drv[i]) phase_m[i] = 0;
        end
      end
    end
  end

  task automatic check(input int i, input string name, input logic [255:0] act, input logic [255:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL inst%0d %s: got %h expected %h at %0t", i, name, act, exp, $time);
  endtask

  initial begin : monitor_proc
    frame_t f;
    int     n;
    logic   final_done;
    final_done = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        check(i, "valid", 256'(val_mon[i]), 256'(lvl_m[i] > 0));
        check(i, "level", 256'(lvl_mon[i]), 256'(lvl_m[i]));
        check(i, "overflow", 256'(ovf_mon[i]), 256'(ovf_m[i]));
        if (rst_seen[i]) begin
          check(i, "reset_result", res_mon[i], 256'd0);
          check(i, "reset_count", 256'(cnt_mon[i]), 256'd0);
        end
        if (val_mon[i]) begin
          n = (i == 0) ? exp_q0.size() : exp_q1.size();
          check(i, "frame_expected", 256'(n > 0), 256'd1);
          if (n > 0) begin
            f = (i == 0) ? exp_q0[0] : exp_q1[0];
            check(i, "result", res_mon[i], f.data);
            check(i, "result_count", 256'(cnt_mon[i]), 256'(f.count));
            if (ready_drv[i]) begin
              if (i == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
            end
          end
        end
      end
      if (final_chk && !final_done) begin
        check(0, "drained", 256'(exp_q0.size()), 256'd0);
        check(1, "drained", 256'(exp_q1.size()), 256'd0);
        final_done = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic beat(input int i, input logic [71:0] m, input logic md, input logic fl);
    mic_drv[i]   = m;
    valid_drv[i] = 1'b1;
    mode_drv[i]  = md;
    flush_drv[i] = fl;
    tick();
    valid_drv[i] = 1'b0;
    flush_drv[i] = 1'b0;
  endtask

  function automatic logic [71:0] rnd72();
    return {8'h00, $urandom, $urandom};
  endfunction

  initial begin : stim_proc
    int          dec [6];
    int          v;
    logic [71:0] m;
    dec = '{100, 300, -7, -8, 8388607, 8388607};
    for (int i = 0; i < 2; i++) begin
      rst_drv[i] = 1'b1; mic_drv[i] = '0; valid_drv[i] = 1'b0;
      mode_drv[i] = 1'b0; flush_drv[i] = 1'b0; ready_drv[i] = 1'b0;
    end
    idle(3);
    rst_drv[0] = 1'b0;
    rst_drv[1] = 1'b0;

    // Basic packing 1..10
    ready_drv[0] = 1'b1;
    for (int k = 1; k <= 10; k++) beat(0, 72'(k), 1'b0, 1'b0);
    idle(3);

    // Decimate: directed pairs then random pairs
    for (int k = 0; k < 20; k++) begin
      v = (k < 6) ? dec[k] : int'($urandom);
      m = 72'(v[23:0]);
      beat(0, m, 1'b1, 1'b0);
    end
    idle(3);

    // Flush with a beat in the flush cycle, then a full frame from slot 0
    for (int k = 0; k < 3; k++) beat(0, rnd72(), 1'b0, 1'b0);
    beat(0, rnd72(), 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) beat(0, rnd72(), 1'b0, 1'b0);
    idle(2);

    // Decimate flush while a first-of-pair sample is held
    for (int k = 0; k < 3; k++) beat(0, rnd72(), 1'b1, 1'b0);
    flush_drv[0] = 1'b1;
    tick();
    flush_drv[0] = 1'b0;
    idle(2);

    // Mode change mid-frame is ignored
    for (int k = 0; k < 2; k++) beat(0, rnd72(), 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) beat(0, rnd72(), 1'b1, 1'b0);
    mode_drv[0] = 1'b0;
    idle(2);

    // Backpressure: five frames into a depth-4 FIFO
    ready_drv[0] = 1'b0;
    for (int k = 0; k < 50; k++) beat(0, rnd72(), 1'b0, 1'b0);
    idle(6);
    ready_drv[0] = 1'b1;
    idle(8);

    // Reset clears overflow; then full FIFO with a pop in the close cycle
    rst_drv[0] = 1'b1;
    idle(2);
    rst_drv[0] = 1'b0;
    ready_drv[0] = 1'b0;
    for (int k = 0; k < 49; k++) beat(0, rnd72(), 1'b0, 1'b0);
    ready_drv[0] = 1'b1;
    beat(0, rnd72(), 1'b0, 1'b0);
    ready_drv[0] = 1'b0;
    idle(3);
    ready_drv[0] = 1'b1;
    idle(8);

    // Three channels: CAP = 9, then reset mid-frame
    ready_drv[1] = 1'b1;
    beat(1, {24'd3, 24'd2, 24'd1}, 1'b0, 1'b0);
    beat(1, {24'd6, 24'd5, 24'd4}, 1'b0, 1'b0);
    beat(1, {24'd9, 24'd8, 24'd7}, 1'b0, 1'b0);
    idle(3);
    beat(1, rnd72(), 1'b0, 1'b0);
    beat(1, rnd72(), 1'b0, 1'b0);
    rst_drv[1] = 1'b1;
    tick();
    rst_drv[1] = 1'b0;
    idle(3);

    // Random traffic on both instances: normal, then heavy backpressure
    for (int phase = 0; phase < 2; phase++) begin
      for (int k = 0; k < ((phase == 0) ? 800 : 300); k++) begin
        for (int i = 0; i < 2; i++) begin
          mic_drv[i]   = rnd72();
          valid_drv[i] = ($urandom_range(0, 9) < 7);
          mode_drv[i]  = 1'($urandom_range(0, 1));
          flush_drv[i] = ($urandom_range(0, 19) == 0);
          ready_drv[i] = (phase == 0) ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 19) == 0);
        end
        tick();
      end
    end

    for (int i = 0; i < 2; i++) begin
      valid_drv[i] = 1'b0; flush_drv[i] = 1'b0; ready_drv[i] = 1'b1;
    end
    idle(10);
    final_chk = 1'b1;
    idle(2);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/mic_frame_packer.md
# mic_frame_packer

Parametrised multichannel successor to the single-mic capture path under `lab_top`. It accepts free-running multichannel microphone samples and optionally decimates them by 2 per channel. It packs the samples into wide `result` frames and buffers completed frames in a small frame FIFO. The frames leave through a valid/ready handshake, so downstream processing can stall without corrupting frame boundaries.

## Interface
- `SAMPLE_W`, 24, bits per mic sample (two's complement).
- `CHANNELS`, 1, mic channels delivered per input beat (1..SLOTS).
- `OUT_W`, 256, frame width; `SLOTS = OUT_W / SAMPLE_W` (integer floor, 10 at defaults).
- `DEPTH`, 4, frame FIFO depth (power of two, ≥2).

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `mic` in CHANNELS*SAMPLE_W: channel c occupies `[c*SAMPLE_W +: SAMPLE_W]`.
- `mic_valid` in 1: a beat is accepted every cycle this is high. There is no input stall.
- `mode` in 1: 0 = pass-through, 1 = per-channel decimate-by-2 average.
- `flush` in 1: close the current partial frame.
- `result` out OUT_W: FIFO head frame; slot k at `[k*SAMPLE_W +: SAMPLE_W]`, unused bits 0.
- `result_count` out $clog2(SLOTS+1): number of valid slots in the head frame.
- `result_valid` out 1: head frame available.
- `result_ready` in 1: consumer accepts the head frame when it is high together with `result_valid`.
- `level` out $clog2(DEPTH+1): frames held in the FIFO.
- `overflow` out 1: sticky; set when a frame is dropped; cleared only by `rst`.

## Operation
- **Frame capacity:** `CAP = (SLOTS / CHANNELS) * CHANNELS`. Each emitted output beat writes its CHANNELS samples into slots `fill .. fill+CHANNELS-1` in channel order. `fill` then advances by CHANNELS.
- **Pass mode:** every accepted `mic` beat is an output beat.
- **Decimate mode:**
  - A per-channel phase bit toggles on each accepted beat.
  - Phase 0 stores the samples.
  - Phase 1 emits `(a + b) >>> 1` per channel, computed in SAMPLE_W+1 bits with a signed sum and an arithmetic shift, then truncated to SAMPLE_W bits. The result always fits.
- **Mode latching:** `mode` is sampled only when `fill == 0` and phase == 0 (frame start). Changes at any other time are ignored until the next frame start.
- **Frame close:** a frame closes when `fill` reaches CAP, or on `flush` with `fill > 0`.
  - On close: push {frame, count = fill} to the FIFO; clear the frame register to 0; set `fill` to 0 and phase to 0.
  - If `flush` arrives with a held phase-0 sample, that sample is discarded.
- **flush with fill == 0:** no push. Phase is still cleared.
- **flush + mic_valid in the same cycle:** the beat is applied first, then the frame closes including it.
- **FIFO full at close:** the frame is dropped, `overflow` is set to 1, and `fill` resets as normal. A pop in the same cycle frees a slot first, so the push succeeds and `overflow` is not set.
- **Output stability:** `result`, `result_count` and `result_valid` are registered FIFO-head outputs. They stay stable while `result_valid && !result_ready`.

## Timing
- **Reset values:** `result` = 0, `result_count` = 0, `result_valid` = 0, `level` = 0, `overflow` = 0. Internal `fill`, phase, frame register and FIFO pointers are all cleared.
- **Reset mid-frame:** the partial frame and all queued frames are discarded with no output.
- **Close-to-output latency:** the frame closes in cycle N (the last beat is accepted, or `flush` is seen). If the FIFO was empty, `result_valid` = 1 in cycle N+1.
- **Pop:** a handshake in cycle N presents the next frame (or `result_valid` = 0) in cycle N+1.
- **Throughput:** one frame per cycle when `result_ready` is held high.
- **level:**
  - Updates the cycle after a push or pop.
  - A simultaneous push and pop leaves it unchanged.
  - It never exceeds DEPTH.

## Test plan
- **Basic packing:** defaults; rst; `mic` = 1..10 on 10 consecutive cycles, `result_ready` = 1 → one frame with slots 0..9 = 1..10, bits 255:240 = 0, count = 10, valid exactly 1 cycle after the 10th beat.
- **Decimate mode:** `mode` = 1; samples 100, 300, -7, -8, 0x7FFFFF, 0x7FFFFF, ... for 20 beats → slots are 200, -8 (0xFFFFF8), 0x7FFFFF, ...; count = 10.
- **Flush:** 3 samples then `flush` (plus a 4th `mic_valid` in the flush cycle) → count = 4, slots 4..9 = 0. Next frame starts at slot 0.
- **Backpressure and overflow:** `result_ready` = 0; 5 full frames → `level` = 4, frame 5 dropped, `overflow` = 1. Releasing ready drains frames 1..4 in order, `result` stable while stalled; `overflow` stays 1 until rst.
- **Full with simultaneous pop:** FIFO full with ready pulsed in the close cycle of a new frame → push accepted, `level` stays 4, `overflow` stays 0.
- **CHANNELS = 3 and mid-frame reset:** CAP = 9; 3 beats {ch0, ch1, ch2} = {1, 2, 3}, {4, 5, 6}, {7, 8, 9} → slots 0..8 = 1..9, count = 9, slot 9 = 0. Asserting rst after 2 beats of the next frame → no frame is emitted and all outputs read 0.
